// File: rtl/sram_arbiter.sv
// Purpose: shares one 32-bit SRAM controller between ifetch (port 0) and load/store (port 1).
// Latency: command 1 cycle after a request is seen in IDLE; port ack 1 cycle after controller ack.
// Backpressure: requesters hold level requests until ack; a single transaction is in flight at once.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-low reset (shared with the controller)
//   i_pN_addr/wdata/bmask requester N command fields, held stable until o_pN_ack
//   i_pN_wren/rden        requester N level request; exactly one high means a request
//   o_pN_rdata, o_pN_ack  captured controller data and one-cycle completion pulse
//   o_m_addr/wdata/bmask  latched command to the controller (change only on grant)
//   o_m_wren/rden         one-cycle command pulse to the controller
//   i_m_rdata, i_m_ack    controller read data and completion pulse
//
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration; otherwise port 1
// wins every simultaneous request (fixed priority).
module sram_arbiter (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [17:0] i_p0_addr,
  input  logic [31:0] i_p0_wdata,
  input  logic [3:0]  i_p0_bmask,
  input  logic        i_p0_wren,
  input  logic        i_p0_rden,
  output logic [31:0] o_p0_rdata,
  output logic        o_p0_ack,
  input  logic [17:0] i_p1_addr,
  input  logic [31:0] i_p1_wdata,
  input  logic [3:0]  i_p1_bmask,
  input  logic        i_p1_wren,
  input  logic        i_p1_rden,
  output logic [31:0] o_p1_rdata,
  output logic        o_p1_ack,
  output logic [17:0] o_m_addr,
  output logic [31:0] o_m_wdata,
  output logic [3:0]  o_m_bmask,
  output logic        o_m_wren,
  output logic        o_m_rden,
  input  logic [31:0] i_m_rdata,
  input  logic        i_m_ack
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  typedef struct packed {
    logic [17:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bmask;
    logic        wr;
  } cmd_t;

  state_t      r_state;
  state_t      w_state_nxt;
  cmd_t        r_cmd;
  cmd_t        w_p0_cmd;
  cmd_t        w_p1_cmd;
  logic        r_port;
  logic [31:0] r_p0_rdata;
  logic [31:0] r_p1_rdata;
  logic        w_p0_req;
  logic        w_p1_req;
  logic        w_win;
  logic        w_grant;
  logic        w_capture;

  // Both enables high is treated as "no request", same as both low.
  assign w_p0_req = i_p0_wren ^ i_p0_rden;
  assign w_p1_req = i_p1_wren ^ i_p1_rden;

  assign w_p0_cmd = '{addr: i_p0_addr, wdata: i_p0_wdata, bmask: i_p0_bmask, wr: i_p0_wren};
  assign w_p1_cmd = '{addr: i_p1_addr, wdata: i_p1_wdata, bmask: i_p1_bmask, wr: i_p1_wren};

`ifdef SRAM_ARB_RR_EN
  // r_ptr names the port that wins a tie; it moves away from whichever port was just served.
  logic r_ptr;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_ptr <= 1'b1;
    end else if (r_state == DONE) begin
      r_ptr <= ~r_port;
    end
  end

  assign w_win = (w_p0_req && w_p1_req) ? r_ptr : w_p1_req;
`else
  // A lone port-0 request still wins because w_p1_req is then low.
  assign w_win = w_p1_req;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_p0_req || w_p1_req) begin
          w_grant     = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        w_state_nxt = WAIT;
      end
      WAIT: begin
        // Controller ack is only meaningful here; elsewhere it is ignored.
        if (i_m_ack) begin
          w_capture   = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_cmd      <= '0;
      r_port     <= 1'b0;
      r_p0_rdata <= '0;
      r_p1_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_port <= w_win;
        r_cmd  <= w_win ? w_p1_cmd : w_p0_cmd;
      end
      // Read data is captured on writes too; only the granted port's copy moves.
      if (w_capture) begin
        if (r_port) begin
          r_p1_rdata <= i_m_rdata;
        end else begin
          r_p0_rdata <= i_m_rdata;
        end
      end
    end
  end

  assign o_m_addr   = r_cmd.addr;
  assign o_m_wdata  = r_cmd.wdata;
  assign o_m_bmask  = r_cmd.bmask;
  assign o_m_wren   = (r_state == ISSUE) &&  r_cmd.wr;
  assign o_m_rden   = (r_state == ISSUE) && !r_cmd.wr;

  assign o_p0_ack   = (r_state == DONE) && !r_port;
  assign o_p1_ack   = (r_state == DONE) &&  r_port;
  assign o_p0_rdata = r_p0_rdata;
  assign o_p1_rdata = r_p1_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Purpose: scoreboard bench for sram_arbiter with a small SRAM controller model.
// Latency: controller acks 2 cycles after a write pulse, 5 cycles after a read pulse.
// Backpressure: requesters hold requests until ack; one transaction at a time.
module tb_sram_arbiter;

`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        i_reset;
  logic [17:0] p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic [3:0]  p0_bmask, p1_bmask;
  logic        p0_wren, p0_rden, p1_wren, p1_rden;
  logic [31:0] o_p0_rdata, o_p1_rdata;
  logic        o_p0_ack, o_p1_ack;
  logic [17:0] o_m_addr;
  logic [31:0] o_m_wdata;
  logic [3:0]  o_m_bmask;
  logic        o_m_wren, o_m_rden;
  logic [31:0] m_rdata;
  logic        m_ack;

  sram_arbiter dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_p0_addr  (p0_addr),
    .i_p0_wdata (p0_wdata),
    .i_p0_bmask (p0_bmask),
    .i_p0_wren  (p0_wren),
    .i_p0_rden  (p0_rden),
    .o_p0_rdata (o_p0_rdata),
    .o_p0_ack   (o_p0_ack),
    .i_p1_addr  (p1_addr),
    .i_p1_wdata (p1_wdata),
    .i_p1_bmask (p1_bmask),
    .i_p1_wren  (p1_wren),
    .i_p1_rden  (p1_rden),
    .o_p1_rdata (o_p1_rdata),
    .o_p1_ack   (o_p1_ack),
    .o_m_addr   (o_m_addr),
    .o_m_wdata  (o_m_wdata),
    .o_m_bmask  (o_m_bmask),
    .o_m_wren   (o_m_wren),
    .o_m_rden   (o_m_rden),
    .i_m_rdata  (m_rdata),
    .i_m_ack    (m_ack)
  );

  typedef struct {
    logic        wr;
    logic [17:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bmask;
    int          cyc;
  } exp_cmd_t;

  typedef struct {
    int          port;
    logic [31:0] rdata;
    int          cyc;
  } exp_ack_t;

  exp_cmd_t    q_cmd[$];
  exp_ack_t    q_ack[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [31:0] ctl_rdata = 32'h0;
  logic        spur_ack = 1'b0;
  logic [31:0] exp_rd0 = 32'h0;
  logic [31:0] exp_rd1 = 32'h0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_p0_rdata"}, o_p0_rdata, 0);
    check({tag, "_p1_rdata"}, o_p1_rdata, 0);
    check({tag, "_m_wdata"}, o_m_wdata, 0);
    check({tag, "_ctl"}, {o_p0_ack, o_p1_ack, o_m_wren, o_m_rden, o_m_bmask, o_m_addr}, 0);
  endtask

  task automatic drive_port(input int p, input logic wr, input logic rd,
                            input logic [17:0] a, input logic [31:0] d, input logic [3:0] m);
    if (p == 0) begin
      p0_wren = wr; p0_rden = rd; p0_addr = a; p0_wdata = d; p0_bmask = m;
    end else begin
      p1_wren = wr; p1_rden = rd; p1_addr = a; p1_wdata = d; p1_bmask = m;
    end
  endtask

  function automatic exp_cmd_t mk_cmd(input logic wr, input logic [17:0] a,
                                      input logic [31:0] d, input logic [3:0] m, input int c);
    exp_cmd_t e;
    e.wr = wr; e.addr = a; e.wdata = d; e.bmask = m; e.cyc = c;
    return e;
  endfunction

  function automatic exp_ack_t mk_ack(input int p, input logic [31:0] r, input int c);
    exp_ack_t e;
    e.port = p; e.rdata = r; e.cyc = c;
    return e;
  endfunction

  // Single transaction: called at a negedge while the arbiter is idle; returns at
  // the negedge of the following idle cycle.
  task automatic do_txn(input int p, input logic wr, input logic [17:0] a,
                        input logic [31:0] d, input logic [3:0] m);
    int n;
    q_cmd.push_back(mk_cmd(wr, a, d, m, cyc + 1));
    q_ack.push_back(mk_ack(p, ctl_rdata, cyc + (wr ? 4 : 7)));
    drive_port(p, wr, !wr, a, d, m);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(p == 1 ? o_p1_ack : o_p0_ack) && n < 20);
    if (!(p == 1 ? o_p1_ack : o_p0_ack)) check("txn_timeout", q_ack.size(), 0);
    drive_port(p, 1'b0, 1'b0, a, d, m);
    @(negedge clk);
  endtask

  // SRAM controller model; shares the reset and returns ctl_rdata only in its ack cycle.
  initial begin
    int cnt;
    cnt = 0;
    m_ack = 1'b0;
    m_rdata = 32'hFFFF_FFFF;
    forever begin
      @(negedge clk);
      m_ack = spur_ack;
      m_rdata = 32'hFFFF_FFFF;
      if (!i_reset) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            m_ack = 1'b1;
            m_rdata = ctl_rdata;
          end
        end
        if (o_m_wren || o_m_rden) cnt = o_m_wren ? 2 : 5;
      end
    end
  end

  // Output monitor: every command pulse and every port ack must match the queue head.
  initial begin
    exp_cmd_t ec;
    exp_ack_t ea;
    int       port;
    forever begin
      @(negedge clk);
      if (o_m_wren || o_m_rden) begin
        check("m_onehot", o_m_wren & o_m_rden, 0);
        if (q_cmd.size() == 0) begin
          check("m_unexp_cmd", {o_m_wren, o_m_rden}, 0);
        end else begin
          ec = q_cmd.pop_front();
          check("m_cyc", cyc, ec.cyc);
          check("m_wren", o_m_wren, ec.wr);
          check("m_rden", o_m_rden, !ec.wr);
          check("m_addr", o_m_addr, ec.addr);
          check("m_wdata", o_m_wdata, ec.wdata);
          check("m_bmask", o_m_bmask, ec.bmask);
        end
      end
      if (o_p0_ack || o_p1_ack) begin
        check("ack_onehot", o_p0_ack & o_p1_ack, 0);
        if (q_ack.size() == 0) begin
          check("p_unexp_ack", {o_p0_ack, o_p1_ack}, 0);
        end else begin
          ea = q_ack.pop_front();
          port = o_p1_ack ? 1 : 0;
          check("ack_port", port, ea.port);
          check("ack_cyc", cyc, ea.cyc);
          check("ack_rdata", port == 1 ? o_p1_rdata : o_p0_rdata, ea.rdata);
          if (ea.port == 1) exp_rd1 = ea.rdata;
          else              exp_rd0 = ea.rdata;
        end
      end
    end
  end

  initial begin
    int n;
    int port;
    int c0;
    i_reset = 1'b0;
    drive_port(0, 1'b0, 1'b1, 18'h00033, 32'h0000_3333, 4'h1);
    drive_port(1, 1'b0, 1'b1, 18'h00044, 32'h0000_4444, 4'h3);
    ctl_rdata = 32'hA5A5_0044;

    // Reset held two cycles with both ports requesting; port 1 wins after release.
    @(negedge clk); chk_zero("rst1");
    @(negedge clk); chk_zero("rst2");
    q_cmd.push_back(mk_cmd(1'b0, 18'h00044, 32'h0000_4444, 4'h3, cyc + 1));
    q_ack.push_back(mk_ack(1, ctl_rdata, cyc + 7));
    i_reset = 1'b1;
    @(negedge clk);
    // Port 1 withdraws after grant (still completes); port 0 withdraws before grant.
    drive_port(0, 1'b0, 1'b0, 18'h0, 32'h0, 4'h0);
    drive_port(1, 1'b0, 1'b0, 18'h0, 32'h0, 4'h0);
    n = 0;
    while (q_ack.size() > 0 && n < 20) begin @(negedge clk); n++; end
    if (q_ack.size() > 0) check("rst_rel_timeout", q_ack.size(), 0);
    repeat (4) @(negedge clk);

    // Port 1 write.
    ctl_rdata = 32'h5A5A_0010;
    do_txn(1, 1'b1, 18'h00010, 32'hDEAD_BEEF, 4'hF);
    repeat (2) @(negedge clk);

    // Port 0 read; port 1's data must hold.
    ctl_rdata = 32'h1234_5678;
    do_txn(0, 1'b0, 18'h00020, 32'h0, 4'hF);
    check("p1_rdata_hold", o_p1_rdata, exp_rd1);
    check("p0_rdata_hold", o_p0_rdata, 32'h1234_5678);
    check("m_addr_hold", o_m_addr, 18'h00020);
    repeat (2) @(negedge clk);

    // Both ports request reads continuously for four back-to-back transactions.
    ctl_rdata = 32'h0BAD_F00D;
    c0 = cyc;
    for (int k = 0; k < 4; k++) begin
      port = RR ? ((k % 2 == 0) ? 1 : 0) : 1;
      q_cmd.push_back(mk_cmd(1'b0, port == 1 ? 18'h00200 : 18'h00100,
                             port == 1 ? 32'h2222_0000 : 32'h1111_0000,
                             port == 1 ? 4'hC : 4'h3, c0 + 1 + 8 * k));
      q_ack.push_back(mk_ack(port, ctl_rdata, c0 + 7 + 8 * k));
    end
    drive_port(0, 1'b0, 1'b1, 18'h00100, 32'h1111_0000, 4'h3);
    drive_port(1, 1'b0, 1'b1, 18'h00200, 32'h2222_0000, 4'hC);
    n = 0;
    while (q_ack.size() > 0 && n < 60) begin @(negedge clk); n++; end
    if (q_ack.size() > 0) check("arb_timeout", q_ack.size(), 0);
    drive_port(0, 1'b0, 1'b0, 18'h0, 32'h0, 4'h0);
    drive_port(1, 1'b0, 1'b0, 18'h0, 32'h0, 4'h0);
    repeat (3) @(negedge clk);

    // Invalid request (both enables) plus a stray controller ack while idle.
    drive_port(0, 1'b1, 1'b1, 18'h00055, 32'h5555_5555, 4'hF);
    repeat (3) @(negedge clk);
    spur_ack = 1'b1;
    @(negedge clk);
    spur_ack = 1'b0;
    repeat (6) @(negedge clk);
    check("spur_p0_rdata", o_p0_rdata, exp_rd0);
    check("spur_p1_rdata", o_p1_rdata, exp_rd1);
    ctl_rdata = 32'h0000_0055;
    do_txn(0, 1'b1, 18'h00055, 32'h5555_5555, 4'h5);
    repeat (2) @(negedge clk);

    // Reset during WAIT of a port 1 read: no ack, everything clears.
    ctl_rdata = 32'h7777_7777;
    q_cmd.push_back(mk_cmd(1'b0, 18'h00077, 32'h0, 4'hF, cyc + 1));
    drive_port(1, 1'b0, 1'b1, 18'h00077, 32'h0, 4'hF);
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    drive_port(1, 1'b0, 1'b0, 18'h0, 32'h0, 4'h0);
    @(negedge clk); chk_zero("rst_mid1");
    @(negedge clk); chk_zero("rst_mid2");
    i_reset = 1'b1;
    exp_rd0 = 32'h0;
    exp_rd1 = 32'h0;
    repeat (8) @(negedge clk);
    check("rst_mid_p1_rdata", o_p1_rdata, 0);
    check("rst_mid_m_addr", o_m_addr, 0);
    ctl_rdata = 32'h0000_0099;
    do_txn(0, 1'b1, 18'h00099, 32'h9999_0000, 4'h2);
    repeat (3) @(negedge clk);

    check("cmd_queue_left", q_cmd.size(), 0);
    check("ack_queue_left", q_ack.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter that shares the single 32-bit SRAM controller between the instruction-fetch port (port 0) and the load/store port (port 1). It sits between the core's memory requesters and the SRAM controller. It converts level-held requester handshakes into the controller's single-cycle command pulse, waits for the controller acknowledge, and returns the result to the granted port.

## Interface
- No parameters.
- i_clk  in  1  clock
- i_reset  in  1  synchronous reset, active-low
- i_p0_addr / i_p1_addr  in  18  halfword address from port n, forwarded unchanged
- i_p0_wdata / i_p1_wdata  in  32  write data
- i_p0_bmask / i_p1_bmask  in  4  byte mask
- i_p0_wren / i_p1_wren  in  1  write request, held until ack
- i_p0_rden / i_p1_rden  in  1  read request, held until ack
- o_p0_rdata / o_p1_rdata  out  32  read data, valid in the ack cycle
- o_p0_ack / o_p1_ack  out  1  one-cycle completion pulse
- o_m_addr, o_m_wdata, o_m_bmask  out  18/32/4  command to the controller
- o_m_wren, o_m_rden  out  1  one-cycle command pulse to the controller
- i_m_rdata  in  32  controller read data
- i_m_ack  in  1  controller completion pulse

## Operation
- A port requests when exactly one of wren/rden is high. Both high or both low means no request.
- The requester holds addr, wdata, bmask and request stable until its ack. The cycle after ack, a still-asserted request counts as a new transaction.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: if any port requests, pick a winner, latch its port id, addr, wdata, bmask and write flag, then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: drive o_m_* from the latched values. Exactly one of o_m_wren/o_m_rden is 1, for this cycle only. Then go to WAIT.
  - WAIT: o_m_wren = o_m_rden = 0. When i_m_ack is 1, capture i_m_rdata (on writes too) and go to DONE.
  - DONE: pulse the ack of the granted port; its rdata output shows the captured data. Update the priority pointer, then go to IDLE.
- o_m_addr/wdata/bmask always show the latched values. They change only on the IDLE->ISSUE transition.
- o_pN_rdata holds the last captured value between transactions. Only the granted port's rdata output is updated.
- i_m_ack is ignored outside WAIT.
- A request that drops before it is granted is never issued. A request withdrawn after grant still completes and is still acked.
- A simultaneous request on both ports in IDLE is resolved per Configuration; the loser stays pending.
- Reset, including mid-transaction: state returns to IDLE with no ack emitted. The pointer favours port 1. All latches and outputs clear. The controller shares i_reset.

## Timing
- Reset values: all o_* = 0.
- Request first seen in IDLE at cycle 0:
  - o_m_* command at cycle 1.
  - The controller acks at cycle 3 for a write and cycle 6 for a read.
  - o_pN_ack at cycle 4 for a write and cycle 7 for a read.
  - IDLE again at cycle 5 for a write and cycle 8 for a read.
- Back-to-back throughput: one write per 5 cycles, one read per 8 cycles.
- No combinational path from i_m_* to o_p*.
- No combinational path from i_p* to o_m_*.

## Configuration
- SRAM_ARB_RR_EN defined: round-robin arbitration. On a simultaneous request, the port not served most recently wins. The pointer updates in DONE to point away from the served port.
- SRAM_ARB_RR_EN undefined: fixed priority. Port 1 (load/store) always wins a simultaneous request. The pointer logic is absent.

## Test plan
- Reset with i_reset=0 for 2 cycles while both ports request → all outputs 0, no o_m_* pulse until 1 cycle after release.
- Port 1 write to addr 0x00010, wdata 0xDEADBEEF, bmask 0xF, requested at cycle 0 → o_m_wren=1 only at cycle 1 with those values; o_p1_ack=1 only at cycle 4.
- Port 0 read of 0x00020, with a controller model returning 0x12345678 → o_m_rden pulse at cycle 1; o_p0_ack at cycle 7 with o_p0_rdata=0x12345678; o_p1_ack stays 0.
- Both ports continuously request reads → grants alternate 1,0,1,0 with RR enabled; with RR disabled, port 1 is served every time and port 0 starves.
- Port 0 drives wren=rden=1 → no command issued, FSM stays IDLE.
- Reset asserted during WAIT of a port 1 read → no ack on any port, FSM in IDLE, o_p1_rdata=0 after release.
